// File: rtl/addsub_serial.sv
// Slice-serial adder/subtractor: SLICE bits per cycle, LSB slice first, WIDTH/SLICE cycles per operation.
// Define ADDSUB_SERIAL_FLAGS_EN to build the ovf/zero flag logic; otherwise both flags are tied to 0.
module addsub_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             ctrl_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] s_r;
   logic             co_r;
   logic             busy_r;
   logic             done_r;

   logic [SLICE-1:0] a_sl_s;
   logic [SLICE-1:0] b_sl_s;
   logic [SLICE:0]   sum_s;
   logic [WIDTH-1:0] result_s;
   logic             last_s;
   logic             accept_s;
   int               base_s;

   // Current slice sum and the full result as it will look after this RUN cycle
   always_comb begin
      base_s   = int'(cnt_r) * SLICE;
      a_sl_s   = a_r[base_s +: SLICE];
      b_sl_s   = b_r[base_s +: SLICE] ^ {SLICE{ctrl_r}};
      sum_s    = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SLICE{1'b0}}, carry_r};
      result_s = s_r;
      result_s[base_s +: SLICE] = sum_s[SLICE-1:0];
      last_s   = (cnt_r == CW'(N - 1));
      accept_s = start && (state_r != RUN);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next-state logic; start is only honoured outside RUN
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nx_s = RUN;
            else       state_nx_s = IDLE;
         end
         RUN: begin
            if (last_s) state_nx_s = DONE;
            else        state_nx_s = RUN;
         end
         DONE: begin
            if (start) state_nx_s = RUN;
            else       state_nx_s = IDLE;
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // Operand latch, slice datapath, carry chain and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         ctrl_r  <= 1'b0;
         carry_r <= 1'b0;
         cnt_r   <= '0;
         s_r     <= '0;
         co_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         busy_r <= (state_nx_s == RUN);
         done_r <= (state_nx_s == DONE);
         if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            ctrl_r  <= ctrl;
            carry_r <= ctrl;
            cnt_r   <= '0;
         end else if (state_r == RUN) begin
            s_r     <= result_s;
            carry_r <= sum_s[SLICE];
            cnt_r   <= cnt_r + CW'(1);
            if (last_s) begin
               co_r <= sum_s[SLICE];
            end
         end
      end
   end

`ifdef ADDSUB_SERIAL_FLAGS_EN
   logic ovf_r;
   logic zero_r;

   // Flags from the completed result; carry into the MSB is recovered as a ^ b' ^ sum at that bit
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r  <= 1'b0;
         zero_r <= 1'b0;
      end else if ((state_r == RUN) && last_s && !accept_s) begin
         ovf_r  <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ ctrl_r ^ result_s[WIDTH-1] ^ sum_s[SLICE];
         zero_r <= (result_s == '0);
      end
   end

   assign ovf  = ovf_r;
   assign zero = zero_r;
`else
   assign ovf  = 1'b0;
   assign zero = 1'b0;
`endif

   assign busy = busy_r;
   assign done = done_r;
   assign s    = s_r;
   assign co   = co_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: directed corner cases plus randomized operations
// checked against an integer-arithmetic reference model.
module tb_addsub_serial;

   typedef struct packed {
      logic [15:0] s;
      logic        co;
      logic        ovf;
      logic        zero;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ctrl;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] s;
   logic        co;
   logic        ovf;
   logic        zero;

   res_t q[$];
   int   checks = 0;
   int   fails  = 0;

   addsub_serial #(.WIDTH(16), .SLICE(4)) dut (
      .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .a(a), .b(b),
      .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
      res_t r;
      int   full;
      int   sval;
      full = c ? (int'(x) + 65536 - int'(y)) : (int'(x) + int'(y));
      sval = c ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
      r.s  = full[15:0];
      r.co = (full >= 65536);
`ifdef ADDSUB_SERIAL_FLAGS_EN
      r.ovf  = (sval > 32767) || (sval < -32768);
      r.zero = (full[15:0] == 16'h0000);
`else
      r.ovf  = 1'b0;
      r.zero = 1'b0;
`endif
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && done === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done: got done=1 expected no pending result");
         end else begin
            res_t e;
            e = q.pop_front();
            chk("s", 32'(s), 32'(e.s));
            chk("co", 32'(co), 32'(e.co));
            chk("ovf", 32'(ovf), 32'(e.ovf));
            chk("zero", 32'(zero), 32'(e.zero));
         end
      end
   end

   // Caller sits at a negedge; start is held across exactly one rising edge
   task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic c);
      a     = x;
      b     = y;
      ctrl  = c;
      start = 1'b1;
      q.push_back(model(x, y, c));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", 32'(n < 20), 32'd1);
   endtask

   initial begin
      int n;
      int seen;
      rst = 1'b1; start = 1'b0; ctrl = 1'b0; a = 16'h0000; b = 16'h0000;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_flags", {29'd0, co, ovf, zero}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Add with busy-length check
      issue(16'h1234, 16'h0FFF, 1'b0);
      n = 0;
      while (busy === 1'b1 && n < 10) begin
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", 32'(n), 32'd4);
      chk("done_after_busy", 32'(done), 32'd1);
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);

      // Subtract with borrow, then signed overflow, then wrap to zero
      issue(16'h0005, 16'h0007, 1'b1); wait_done(); @(negedge clk);
      issue(16'h8000, 16'h0001, 1'b1); wait_done(); @(negedge clk);
      issue(16'hFFFF, 16'h0001, 1'b0); wait_done(); @(negedge clk);

      // Start during RUN is ignored; start in DONE is taken back-to-back
      issue(16'h0001, 16'h0001, 1'b0);
      a = 16'h00FF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      issue(16'h0003, 16'h0001, 1'b1);
      chk("b2b_busy", 32'(busy), 32'd1);
      wait_done(); @(negedge clk);

      // Reset in the second RUN cycle aborts without a done pulse
      a = 16'h0001; b = 16'h0001; ctrl = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_s", 32'(s), 32'd0);
      chk("abort_co", 32'(co), 32'd0);
      seen = 0;
      repeat (6) begin
         if (done === 1'b1) seen = 1;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      issue(16'h0001, 16'h0001, 1'b0); wait_done(); @(negedge clk);

      // Randomized operations, sometimes back-to-back, sometimes with gaps
      for (int i = 0; i < 40; i++) begin
         logic [15:0] x;
         logic [15:0] y;
         x = 16'($urandom);
         y = 16'($urandom);
         if ($urandom_range(0, 7) == 0) y = x;
         if ($urandom_range(0, 7) == 0) x = 16'h8000;
         issue(x, y, 1'($urandom_range(0, 1)));
         wait_done();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (8) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits; WIDTH >= 4.
REQ-002 SHALL have parameter SLICE, default 4: bits processed per cycle; WIDTH is an integer multiple of SLICE. N = WIDTH/SLICE below.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request a new operation; sampled on clk.
REQ-006 SHALL have port ctrl  input  1  operation select; 0 = A+B, 1 = A-B; sampled with start.
REQ-007 SHALL have port a  input  WIDTH  operand A; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  operand B; sampled with start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port s  output  WIDTH  sum/difference.
REQ-012 SHALL have port co  output  1  carry out of the MSB; for subtract, 1 = no borrow (A >= B unsigned).
REQ-013 SHALL have port ovf  output  1  two's-complement overflow flag.
REQ-014 SHALL have port zero  output  1  high when s == 0.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 In IDLE or DONE, start=1 SHALL latch a, b and ctrl, load the carry register with ctrl, clear the slice counter, and move to RUN.
REQ-017 In RUN, each cycle SHALL compute one SLICE-bit slice, LSB slice first: slice(A) + (slice(B) XOR {SLICE{ctrl}}) + carry. The low SLICE bits go to the matching slice of s; the carry-out goes to the carry register.
REQ-018 After the N-th RUN cycle the FSM SHALL move to DONE. co SHALL take the final carry, and ovf and zero SHALL be updated from the completed result in the same edge.
REQ-019 done SHALL be high for exactly the one cycle the FSM is in DONE. With start sampled at edge k, done is high in the cycle following edge k+N.
REQ-020 busy SHALL be high exactly while the FSM is in RUN.
REQ-021 In RUN, start SHALL be ignored; the latched operands and ctrl SHALL NOT change.
REQ-022 A start sampled in the DONE cycle SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-023 DONE SHALL return to IDLE unless start is high.
REQ-024 s, co, ovf and zero SHALL hold their last result from DONE until the next accepted start. During RUN they are not guaranteed valid.
REQ-025 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH; no output wider than WIDTH.

Reset
REQ-027 With rst=1 at a clock edge, the FSM SHALL go to IDLE. busy, done, s, co, ovf and zero SHALL become 0, and the carry register and slice counter SHALL be cleared.
REQ-028 rst SHALL take priority over start. A reset during RUN SHALL abort the operation, and no done pulse SHALL follow.

Configuration
REQ-029 Macro ADDSUB_SERIAL_FLAGS_EN defined: ovf and zero SHALL behave per REQ-013/014/018/025.
REQ-030 Macro ADDSUB_SERIAL_FLAGS_EN undefined: ovf and zero SHALL be constant 0 and no flag logic SHALL be synthesised; s, co, busy and done are unchanged.

Verification (WIDTH=16, SLICE=4, N=4, ADDSUB_SERIAL_FLAGS_EN defined unless stated)
REQ-031 Add: start with a=0x1234, b=0x0FFF, ctrl=0 -> busy high for 4 cycles, done one cycle later; s=0x2233, co=0, ovf=0, zero=0.
REQ-032 Subtract: a=0x0005, b=0x0007, ctrl=1 -> s=0xFFFE, co=0, ovf=0, zero=0. Then a=0x8000, b=0x0001, ctrl=1 -> s=0x7FFF, co=1, ovf=1.
REQ-033 Wrap: a=0xFFFF, b=0x0001, ctrl=0 -> s=0x0000, co=1, zero=1, ovf=0. Rerun with the macro undefined -> s=0x0000, co=1, zero=0, ovf=0.
REQ-034 Busy/back-to-back:
- start a=1, b=1 add; re-assert start with a=0x00FF during RUN -> ignored, s=0x0002.
- start a=3, b=1 subtract in the DONE cycle -> accepted, next done gives s=0x0002 with no idle cycle between.
REQ-035 Reset: rst=1 at the 2nd RUN cycle -> next cycle IDLE, busy=0, s=0, co=0, no done pulse. A subsequent start of 0x0001+0x0001 gives s=0x0002.
